collisions: RTL and testbench

COLLISIONS -- requirements
Module: collisions

---
 rtl/collisions.sv | 145 ++++++++++++++
 tb/tb_collisions.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/collisions.sv
// Snake game shared types and the collision/eat/result evaluator that runs once per game step.
// A step is a rising edge of clk_div seen in the clk domain; all outputs are registered.
package snake_pkg;
  localparam int MAP_WIDTH        = 16;
  localparam int MAP_HEIGHT       = 12;
  localparam int MAX_SNAKE_LENGTH = 16;
  localparam int START_POS_X      = 8;
  localparam int START_POS_Y      = 6;
  localparam int XW = $clog2(MAP_WIDTH);
  localparam int YW = $clog2(MAP_HEIGHT);
  localparam int LW = $clog2(MAX_SNAKE_LENGTH + 1);

  typedef enum logic [2:0] {EMPTY, WALL, SNAKE1, SNAKE2, POINT} tile_t;
  typedef enum logic [2:0] {NONE, UP, DOWN, LEFT, RIGHT} dir_t;
  typedef enum logic [1:0] {MENU, GAME, OVER} mode_t;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } pos_s;

  typedef struct packed {
    logic [LW-1:0]                length;
    logic [XW-1:0]                head_x;
    logic [YW-1:0]                head_y;
    logic [XW-1:0]                tail_x;
    logic [YW-1:0]                tail_y;
    pos_s [MAX_SNAKE_LENGTH-1:0]  segments;
  } snake_s;

  typedef struct packed {
    tile_t [MAP_HEIGHT-1:0][MAP_WIDTH-1:0] tiles;
    snake_s                                snake1;
    snake_s                                snake2;
  } map_s;
endpackage

module collisions
  import snake_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clk_div,
  input  dir_t  dir1,
  input  dir_t  dir2,
  input  map_s  map,
  output map_s  map_nxt,
  input  mode_t mode,
  input  logic  eaten1_pre,
  input  logic  eaten2_pre,
  output logic  eaten1,
  output logic  eaten2,
  output logic  won,
  output logic  lost,
  output logic  draw
);

  typedef struct packed {
    logic          oob;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } head_t;

  function automatic head_t next_head(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                      input dir_t d);
    head_t h;
    h.oob = 1'b0;
    h.x   = x;
    h.y   = y;
    case (d)
      UP:      if (y == '0) h.oob = 1'b1; else h.y = y - YW'(1);
      DOWN:    if (y == YW'(MAP_HEIGHT - 1)) h.oob = 1'b1; else h.y = y + YW'(1);
      LEFT:    if (x == '0) h.oob = 1'b1; else h.x = x - XW'(1);
      RIGHT:   if (x == XW'(MAP_WIDTH - 1)) h.oob = 1'b1; else h.x = x + XW'(1);
      default: ;
    endcase
    return h;
  endfunction

  // A vacating tail is free to enter; a tail that stays put because its snake just grew is solid.
  function automatic logic hits(input head_t h, input tile_t t, input map_s m,
                                input logic ep1, input logic ep2);
    logic on1, on2, solid;
    on1   = (h.x == m.snake1.tail_x) && (h.y == m.snake1.tail_y);
    on2   = (h.x == m.snake2.tail_x) && (h.y == m.snake2.tail_y);
    solid = (t == WALL) || (t == SNAKE1) || (t == SNAKE2);
    return h.oob | (on1 & ep1) | (on2 & ep2) | (solid & ~((on1 & ~ep1) | (on2 & ~ep2)));
  endfunction

  logic  clk_div_q;
  logic  armed;
  logic  step;
  logic  mv1, mv2, same_head;
  logic  col1, col2, eat1, eat2;
  head_t nh1, nh2;
  tile_t t1, t2;

  always_comb begin
    nh1 = next_head(map.snake1.head_x, map.snake1.head_y, dir1);
    nh2 = next_head(map.snake2.head_x, map.snake2.head_y, dir2);
    mv1 = (dir1 != NONE);
    mv2 = (dir2 != NONE);
    t1  = nh1.oob ? EMPTY : map.tiles[nh1.y][nh1.x];
    t2  = nh2.oob ? EMPTY : map.tiles[nh2.y][nh2.x];
    same_head = mv1 & mv2 & ~nh1.oob & ~nh2.oob & (nh1.x == nh2.x) & (nh1.y == nh2.y);
    col1 = mv1 & (hits(nh1, t1, map, eaten1_pre, eaten2_pre) | same_head);
    col2 = mv2 & (hits(nh2, t2, map, eaten1_pre, eaten2_pre) | same_head);
    eat1 = mv1 & ~col1 & (t1 == POINT);
    eat2 = mv2 & ~col2 & (t2 == POINT);
    // armed keeps a clk_div that is already high at reset release from posing as a fresh edge
    step = armed & clk_div & ~clk_div_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_div_q <= 1'b0;
      armed     <= 1'b0;
      map_nxt   <= '0;
      eaten1    <= 1'b0;
      eaten2    <= 1'b0;
      won       <= 1'b0;
      lost      <= 1'b0;
      draw      <= 1'b0;
    end else begin
      clk_div_q <= clk_div;
      armed     <= armed | ~clk_div;
      eaten1    <= 1'b0;
      eaten2    <= 1'b0;
      if (mode != GAME) begin
        map_nxt <= map;
        won     <= 1'b0;
        lost    <= 1'b0;
        draw    <= 1'b0;
      end else if (step && !(won || lost || draw)) begin
        map_nxt <= map;
        eaten1  <= eat1;
        eaten2  <= eat2;
        if (col1 && col2)  draw <= 1'b1;
        else if (col1)     lost <= 1'b1;
        else if (col2)     won  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_collisions.sv
// Bench for collisions: table of hand-derived vectors, reset/stickiness sequences, and random
// maps checked against a coordinate-level model of the game rules.
module tb_collisions;
  import snake_pkg::*;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  logic  clk_div = 1'b0;
  dir_t  dir1 = NONE;
  dir_t  dir2 = NONE;
  map_s  map = '0;
  map_s  map_nxt;
  mode_t mode = MENU;
  logic  eaten1_pre = 1'b0;
  logic  eaten2_pre = 1'b0;
  logic  eaten1, eaten2, won, lost, draw;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  collisions dut (
    .clk(clk), .rst(rst), .clk_div(clk_div), .dir1(dir1), .dir2(dir2), .map(map),
    .map_nxt(map_nxt), .mode(mode), .eaten1_pre(eaten1_pre), .eaten2_pre(eaten2_pre),
    .eaten1(eaten1), .eaten2(eaten2), .won(won), .lost(lost), .draw(draw)
  );

  typedef struct {
    string    name;
    int       h1x, h1y, t1x, t1y, h2x, h2y, t2x, t2y;
    dir_t     d1, d2;
    bit       ep1, ep2;
    int       px, py;
    bit       border;
    bit [4:0] exp;
  } vec_t;

  vec_t tbl[16];

  task automatic checkOutput(string name, logic [4:0] act, logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: {won,lost,draw,eaten1,eaten2} got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkMap(string name, map_s exp);
    int diff;
    diff = 0;
    n_checks++;
    if (map_nxt !== exp) begin
      for (int y = 0; y < MAP_HEIGHT; y++)
        for (int x = 0; x < MAP_WIDTH; x++)
          if (map_nxt.tiles[y][x] !== exp.tiles[y][x]) diff++;
      n_fail++;
      $display("[TB] FAIL %s: map_nxt differs in %0d tiles, snake1 head got (%0d,%0d) expected (%0d,%0d)",
               name, diff, map_nxt.snake1.head_x, map_nxt.snake1.head_y,
               exp.snake1.head_x, exp.snake1.head_y);
    end
  endtask

  function automatic map_s buildMap(vec_t v);
    map_s m;
    m = '0;
    for (int y = 0; y < MAP_HEIGHT; y++)
      for (int x = 0; x < MAP_WIDTH; x++)
        if (v.border && (x == 0 || y == 0 || x == MAP_WIDTH - 1 || y == MAP_HEIGHT - 1))
          m.tiles[y][x] = WALL;
    if (v.px >= 0) m.tiles[v.py][v.px] = POINT;
    m.tiles[v.h1y][v.h1x] = SNAKE1;
    m.tiles[v.t1y][v.t1x] = SNAKE1;
    m.tiles[v.h2y][v.h2x] = SNAKE2;
    m.tiles[v.t2y][v.t2x] = SNAKE2;
    m.snake1.length = LW'(2);
    m.snake1.head_x = XW'(v.h1x);
    m.snake1.head_y = YW'(v.h1y);
    m.snake1.tail_x = XW'(v.t1x);
    m.snake1.tail_y = YW'(v.t1y);
    m.snake2.length = LW'(2);
    m.snake2.head_x = XW'(v.h2x);
    m.snake2.head_y = YW'(v.h2y);
    m.snake2.tail_x = XW'(v.t2x);
    m.snake2.tail_y = YW'(v.t2y);
    return m;
  endfunction

  // Game rules on plain integer coordinates: returns {won,lost,draw,eaten1,eaten2}.
  function automatic bit [4:0] model(map_s m, dir_t d1, dir_t d2, bit ep1, bit ep2);
    int    hx[2], hy[2], tx[2], ty[2], nx[2], ny[2];
    bit    mv[2], oob[2], col[2], eat[2], ep[2];
    dir_t  d[2];
    tile_t t;
    hx[0] = int'(m.snake1.head_x); hy[0] = int'(m.snake1.head_y);
    tx[0] = int'(m.snake1.tail_x); ty[0] = int'(m.snake1.tail_y);
    hx[1] = int'(m.snake2.head_x); hy[1] = int'(m.snake2.head_y);
    tx[1] = int'(m.snake2.tail_x); ty[1] = int'(m.snake2.tail_y);
    d[0] = d1; d[1] = d2; ep[0] = ep1; ep[1] = ep2;
    for (int s = 0; s < 2; s++) begin
      mv[s]  = (d[s] != NONE);
      nx[s]  = hx[s] + int'(d[s] == RIGHT) - int'(d[s] == LEFT);
      ny[s]  = hy[s] + int'(d[s] == DOWN) - int'(d[s] == UP);
      oob[s] = nx[s] < 0 || nx[s] >= MAP_WIDTH || ny[s] < 0 || ny[s] >= MAP_HEIGHT;
      col[s] = 1'b0;
      eat[s] = 1'b0;
      if (!mv[s]) continue;
      if (oob[s]) col[s] = 1'b1;
      else begin
        t = m.tiles[ny[s]][nx[s]];
        if (nx[s] == tx[0] && ny[s] == ty[0])      col[s] = ep[0];
        else if (nx[s] == tx[1] && ny[s] == ty[1]) col[s] = ep[1];
        else col[s] = (t == WALL) || (t == SNAKE1) || (t == SNAKE2);
        eat[s] = (t == POINT);
      end
    end
    if (mv[0] && mv[1] && nx[0] == nx[1] && ny[0] == ny[1]) begin
      col[0] = 1'b1;
      col[1] = 1'b1;
    end
    return {!col[0] && col[1], col[0] && !col[1], col[0] && col[1],
            eat[0] && !col[0], eat[1] && !col[1]};
  endfunction

  // Clears results via MENU, then gives one clk_div edge in GAME; returns just after the step.
  task automatic applyStimulus(map_s m, dir_t d1, dir_t d2, bit ep1, bit ep2);
    @(negedge clk);
    mode = MENU; map = m; dir1 = d1; dir2 = d2;
    eaten1_pre = ep1; eaten2_pre = ep2; clk_div = 1'b0;
    @(negedge clk);
    checkOutput("menu clears", {won, lost, draw, eaten1, eaten2}, 5'b0);
    mode = GAME; clk_div = 1'b1;
    @(negedge clk);
    clk_div = 1'b0;
  endtask

  task automatic runVector(string name, map_s m, dir_t d1, dir_t d2, bit ep1, bit ep2,
                           bit [4:0] exp);
    applyStimulus(m, d1, d2, ep1, ep2);
    checkOutput({name, " result"}, {won, lost, draw, eaten1, eaten2}, exp);
    checkMap({name, " map_nxt"}, m);
    @(negedge clk);
    checkOutput({name, " pulse end"}, {won, lost, draw, eaten1, eaten2}, {exp[4:2], 2'b00});
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    map_s     m0, m1, m;
    vec_t     v;
    bit [4:0] exp;
    int       xs[4], ys[4];
    bit       ok;

    tbl[0]  = '{"start_eat",      8,6,8,8,   3,6,3,8,   UP,UP,     1'b0,1'b0, 8,5,  1'b1, 5'b00010};
    tbl[1]  = '{"s1_wall",        5,1,5,3,   10,6,10,8, UP,UP,     1'b0,1'b0, -1,-1, 1'b1, 5'b01000};
    tbl[2]  = '{"s2_wall",        5,5,5,7,   10,1,10,3, UP,UP,     1'b0,1'b0, -1,-1, 1'b1, 5'b10000};
    tbl[3]  = '{"both_wall",      5,1,5,3,   10,1,10,3, UP,UP,     1'b0,1'b0, -1,-1, 1'b1, 5'b00100};
    tbl[4]  = '{"facing",         4,5,2,5,   6,5,8,5,   RIGHT,LEFT,1'b0,1'b0, -1,-1, 1'b1, 5'b00100};
    tbl[5]  = '{"own_tail_free",  5,5,5,4,   10,6,10,8, UP,UP,     1'b0,1'b0, -1,-1, 1'b1, 5'b00000};
    tbl[6]  = '{"own_tail_grow",  5,5,5,4,   10,6,10,8, UP,UP,     1'b1,1'b0, -1,-1, 1'b1, 5'b01000};
    tbl[7]  = '{"s2_tail_free",   5,5,3,5,   8,5,6,5,   RIGHT,DOWN,1'b0,1'b0, -1,-1, 1'b1, 5'b00000};
    tbl[8]  = '{"s2_tail_grow",   5,5,3,5,   8,5,6,5,   RIGHT,DOWN,1'b0,1'b1, -1,-1, 1'b1, 5'b01000};
    tbl[9]  = '{"both_none",      5,1,5,3,   10,1,10,3, NONE,NONE, 1'b0,1'b0, -1,-1, 1'b1, 5'b00000};
    tbl[10] = '{"s2_eat",         8,6,8,8,   3,6,3,8,   LEFT,UP,   1'b0,1'b0, 3,5,  1'b1, 5'b00001};
    tbl[11] = '{"oob_left",       5,5,5,7,   0,3,2,3,   UP,LEFT,   1'b0,1'b0, -1,-1, 1'b0, 5'b10000};
    tbl[12] = '{"oob_top",        5,0,5,2,   10,6,10,8, UP,UP,     1'b0,1'b0, -1,-1, 1'b0, 5'b01000};
    tbl[13] = '{"body_hit",       5,5,3,5,   6,5,6,3,   RIGHT,DOWN,1'b0,1'b0, -1,-1, 1'b1, 5'b01000};
    tbl[14] = '{"heads_on_point", 4,5,2,5,   6,5,8,5,   RIGHT,LEFT,1'b0,1'b0, 5,5,  1'b1, 5'b00100};
    tbl[15] = '{"oob_corner",     15,11,13,11, 3,11,3,9, RIGHT,DOWN,1'b0,1'b0, -1,-1, 1'b0, 5'b00100};

    // Reset state
    #12;
    checkOutput("reset outputs", {won, lost, draw, eaten1, eaten2}, 5'b0);
    checkMap("reset map_nxt", '0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 16; i++)
      runVector(tbl[i].name, buildMap(tbl[i]), tbl[i].d1, tbl[i].d2, tbl[i].ep1, tbl[i].ep2,
                tbl[i].exp);

    // Result is sticky and freezes evaluation, map_nxt and eaten
    m1 = buildMap(tbl[1]);
    m0 = buildMap(tbl[0]);
    runVector("sticky_setup", m1, UP, UP, 1'b0, 1'b0, 5'b01000);
    @(negedge clk);
    map = m0; eaten1_pre = 1'b0; eaten2_pre = 1'b0; clk_div = 1'b1;
    @(negedge clk);
    clk_div = 1'b0;
    checkOutput("sticky lost", {won, lost, draw, eaten1, eaten2}, 5'b01000);
    checkMap("sticky map hold", m1);

    // Asynchronous reset mid-step, then a fresh clk_div edge is required
    @(negedge clk);
    clk_div = 1'b1;
    #2 rst = 1'b0;
    #1;
    checkOutput("async reset", {won, lost, draw, eaten1, eaten2}, 5'b0);
    checkMap("async reset map", '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("no stale edge %0d", k), {won, lost, draw, eaten1, eaten2}, 5'b0);
    end
    checkMap("no step map", '0);
    clk_div = 1'b0;
    @(negedge clk);
    clk_div = 1'b1;
    @(negedge clk);
    clk_div = 1'b0;
    checkOutput("fresh edge eat", {won, lost, draw, eaten1, eaten2}, 5'b00010);
    checkMap("fresh edge map", m0);

    // map_nxt follows map every clk outside GAME
    @(negedge clk);
    mode = MENU; map = m1;
    @(negedge clk);
    checkMap("menu track 1", m1);
    m = buildMap(tbl[4]);
    map = m;
    @(negedge clk);
    checkMap("menu track 2", m);

    // Random maps against the model
    for (int i = 0; i < 40; i++) begin
      do begin
        for (int k = 0; k < 4; k++) begin
          xs[k] = $urandom_range(0, MAP_WIDTH - 1);
          ys[k] = $urandom_range(0, MAP_HEIGHT - 1);
        end
        ok = 1'b1;
        for (int a = 0; a < 4; a++)
          for (int b = a + 1; b < 4; b++)
            if (xs[a] == xs[b] && ys[a] == ys[b]) ok = 1'b0;
      end while (!ok);
      v.name = "rand";
      v.h1x = xs[0]; v.h1y = ys[0]; v.t1x = xs[1]; v.t1y = ys[1];
      v.h2x = xs[2]; v.h2y = ys[2]; v.t2x = xs[3]; v.t2y = ys[3];
      v.d1 = dir_t'($urandom_range(0, 4));
      v.d2 = dir_t'($urandom_range(0, 4));
      v.ep1 = 1'($urandom_range(0, 1));
      v.ep2 = 1'($urandom_range(0, 1));
      v.px = -1; v.py = -1;
      v.border = 1'($urandom_range(0, 1));
      v.exp = 5'b0;
      m = buildMap(v);
      for (int y = 1; y < MAP_HEIGHT - 1; y++)
        for (int x = 1; x < MAP_WIDTH - 1; x++)
          if (m.tiles[y][x] == EMPTY) begin
            case ($urandom_range(0, 7))
              0:       m.tiles[y][x] = WALL;
              1:       m.tiles[y][x] = POINT;
              default: ;
            endcase
          end
      exp = model(m, v.d1, v.d2, v.ep1, v.ep2);
      runVector($sformatf("rand%0d", i), m, v.d1, v.d2, v.ep1, v.ep2, exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
